ddr_delay_lane_ctrl: RTL

Multi-lane synthesizable controller for DLL-referenced input delay cells (the LOADN/MOVE/DIRECTION/CFLAG style primitive used on DQS/DQ capture paths). It holds a per-lane shadow of each cell's delay code. It accepts load, single-step and go-to-target commands over a valid/ready port, and sequences correctly-timed LOADN and MOVE pulses to the selected lane. It sits between the DDR3 read-leveling/training logic and the per-lane delay primitives, and reports each lane's code and saturation flag.

---
 rtl/ddr_delay_lane_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ddr_delay_lane_ctrl.sv
// Shadows and drives per-lane DLL delay cells (LOADN/MOVE/DIRECTION) from load/step/goto commands.
// Commands are decoded one cycle after acceptance; lanes are serviced one at a time.
module ddr_delay_lane_ctrl #(
  parameter int LANES    = 2,
  parameter int CODE_W   = 8,
  parameter int MOVE_HI  = 2,
  parameter int MOVE_GAP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CODE_W-1:0]          base_code,
  input  logic                       base_valid,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(LANES)-1:0]   cmd_lane,
  input  logic                       cmd_dir,
  input  logic [CODE_W-1:0]          cmd_target,
  output logic [LANES-1:0]           dly_loadn,
  output logic [LANES-1:0]           dly_move,
  output logic [LANES-1:0]           dly_direction,
  output logic [LANES*CODE_W-1:0]    lane_code,
  output logic [LANES-1:0]           lane_cflag,
  output logic                       busy
);
  localparam int LANE_W = $clog2(LANES);
  localparam int MAXC   = (MOVE_HI > MOVE_GAP) ? MOVE_HI : MOVE_GAP;
  localparam int CNT_W  = $clog2(MAXC) + 1;
  localparam logic [CODE_W-1:0] CODE_MAX = '1;
  localparam logic [LANE_W:0]   LANES_C  = (LANE_W+1)'(LANES);
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_GOTO = 2'b10;

  typedef enum logic [2:0] {IDLE, LOADP, SETUP, PULSE, GAP} state_t;

  state_t              state_q, state_d;
  logic                pend_q;
  logic [1:0]          op_q;
  logic [LANE_W-1:0]   lane_q;
  logic                dir_q;
  logic [CODE_W-1:0]   tgt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CODE_W-1:0]   code_q  [LANES];
  logic                ldir_q  [LANES];
  logic                cflag_q [LANES];

  logic                accept, lane_ok, refuse, act, refuse_now, go_dir;
  logic [LANE_W-1:0]   lane_s;
  logic [CODE_W-1:0]   cur_code, sel_code, nxt_code;

  function automatic logic sat(input logic [CODE_W-1:0] c, input logic d);
    return (c == CODE_MAX && !d) || (c == '0 && d);
  endfunction

  assign cmd_ready = !rst && state_q == IDLE && !pend_q;
  assign busy      = !rst && !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign lane_ok   = {1'b0, cmd_lane} < LANES_C;
  assign lane_s    = lane_ok ? cmd_lane : '0;
  assign cur_code  = code_q[lane_s];
  assign sel_code  = code_q[lane_q];
  assign nxt_code  = ldir_q[lane_q] ? sel_code - CODE_W'(1) : sel_code + CODE_W'(1);
  assign go_dir    = (op_q == OP_GOTO) ? !(tgt_q > sel_code) : dir_q;

  // Refused steps and already-reached gotos finish at acceptance and never go pending.
  always_comb begin
    refuse     = (!cmd_dir && cur_code == CODE_MAX) || (cmd_dir && cur_code == '0);
    act        = 1'b0;
    refuse_now = 1'b0;
    if (accept && lane_ok) begin
      case (cmd_op)
        OP_LOAD: act = 1'b1;
        OP_STEP: begin
          act        = !refuse;
          refuse_now = refuse;
        end
        OP_GOTO: act = (cmd_target != cur_code);
        default: act = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pend_q) state_d = (op_q == OP_LOAD) ? LOADP : SETUP;
      LOADP: state_d = IDLE;
      SETUP: state_d = PULSE;
      PULSE: if (cnt_q == CNT_W'(MOVE_HI - 1)) state_d = GAP;
      GAP:   if (cnt_q == CNT_W'(MOVE_GAP - 1))
               state_d = (op_q == OP_GOTO && sel_code != tgt_q) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      op_q   <= 2'b11;
      lane_q <= '0;
      dir_q  <= 1'b0;
      tgt_q  <= '0;
      cnt_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        code_q[l]  <= '0;
        ldir_q[l]  <= 1'b0;
        cflag_q[l] <= 1'b0;
      end
    end else begin
      pend_q <= act;
      cnt_q  <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      if (accept) begin
        op_q   <= cmd_op;
        lane_q <= lane_s;
        dir_q  <= cmd_dir;
        tgt_q  <= cmd_target;
      end
      if (refuse_now) begin
        ldir_q[lane_s]  <= cmd_dir;
        cflag_q[lane_s] <= 1'b1;
      end
      if (state_q == LOADP) begin
        code_q[lane_q]  <= base_valid ? base_code : '0;
        ldir_q[lane_q]  <= 1'b0;
        cflag_q[lane_q] <= 1'b0;
      end
      if (state_d == SETUP && state_q != SETUP) begin
        ldir_q[lane_q]  <= go_dir;
        cflag_q[lane_q] <= sat(sel_code, go_dir);
      end
      // Code moves on the falling edge of MOVE, matching the cell's own update.
      if (state_q == PULSE && state_d == GAP) begin
        code_q[lane_q]  <= nxt_code;
        cflag_q[lane_q] <= sat(nxt_code, ldir_q[lane_q]);
      end
    end
  end

  always_comb begin
    dly_loadn     = '1;
    dly_move      = '0;
    dly_direction = '0;
    lane_code     = '0;
    lane_cflag    = '0;
    for (int l = 0; l < LANES; l++) begin
      dly_loadn[l]                 = !(state_q == LOADP && lane_q == LANE_W'(l));
      dly_move[l]                  = (state_q == PULSE && lane_q == LANE_W'(l));
      dly_direction[l]             = ldir_q[l];
      lane_code[l*CODE_W +: CODE_W] = code_q[l];
      lane_cflag[l]                = cflag_q[l];
    end
  end
endmodule
